// File: rtl/mux_rr_sampler_pkg.sv
// Shared definitions for the round-robin mux sampler: FSM state encoding
// and default sizing parameters.
package mux_rr_sampler_pkg;

   localparam int N_DEF      = 32;
   localparam int SW_DEF     = 5;
   localparam int SETTLE_DEF = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/mux_rr_sampler_if.sv
// Bundle of request, mux and result-handshake signals for the sampler.
// The slave modport is the sampler's view; the master modport is the
// surrounding system (request sources, external mux, result consumer).
interface mux_rr_sampler_if
   import mux_rr_sampler_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int SW = SW_DEF
);
   logic [N-1:0]  req;
   logic          mux_out;
   logic [SW-1:0] sel;
   logic [N-1:0]  gnt;
   logic          busy;
   logic          out_valid;
   logic          out_bit;
   logic [SW-1:0] out_idx;
   logic          out_ready;

   modport slave (
      input  req, mux_out, out_ready,
      output sel, gnt, busy, out_valid, out_bit, out_idx
   );

   modport master (
      output req, mux_out, out_ready,
      input  sel, gnt, busy, out_valid, out_bit, out_idx
   );
endinterface

// File: rtl/mux_rr_sampler_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// above ptr, scanning upward and wrapping from N-1 back to 0.
module rr_pick
   import mux_rr_sampler_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int SW = SW_DEF
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          found,
   output logic [SW-1:0] idx
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   rot;
   logic [SW-1:0]  off;

   // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation
   always_comb begin
      req_dbl = {req, req};
      rot     = req_dbl[ptr +: N];
      off     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = SW'(i);
         end
      end
      found = |req;
      idx   = off + ptr;
   end

endmodule

// File: rtl/mux_rr_sampler.sv
// Round-robin scheduler sharing one external N:1 bit mux among N requesters.
// A grant drives sel, waits SETTLE cycles, samples mux_out and offers the
// bit plus its index on a valid/ready handshake. Grants are never revoked.
module mux_rr_sampler
   import mux_rr_sampler_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int SW     = SW_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input logic             clk,
   input logic             rst_n,
   mux_rr_sampler_if.slave bus
);

   localparam int CW = 3;

   state_t        state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;
   logic          out_bit_q, out_bit_d;
   logic [SW-1:0] out_idx_q, out_idx_d;

   logic          pick_found;
   logic [SW-1:0] pick_idx;

   rr_pick #(
      .N  (N),
      .SW (SW)
   ) u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next-state and register-update logic for the grant/settle/capture/hold cycle
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_idx_d   = out_idx_q;

      case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            if (pick_found) begin
               sel_d   = pick_idx;
               gnt_d   = N'(1) << pick_idx;
               cnt_d   = CW'(SETTLE);
               state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            out_bit_d   = bus.mux_out;
            out_idx_d   = sel_q;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               gnt_d       = '0;
               ptr_d       = sel_q + SW'(1);
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         gnt_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = out_bit_q;
   assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_mux_rr_sampler.sv
// Directed testbench for mux_rr_sampler with a behavioural 32:1 mux.
module tb_mux_rr_sampler;
   import mux_rr_sampler_pkg::*;

   localparam int N  = 32;
   localparam int SW = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] mux_in;
   int           n_vec  = 0;
   int           n_miss = 0;

   typedef struct {
      logic [31:0] req;
      logic [31:0] mux;
      logic [4:0]  idx;
      logic        exp_bit;
   } vec_t;

   vec_t vecs [12];

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   mux_rr_sampler_if #(.N(N), .SW(SW)) bus ();

   // External 32:1 mux selected by the sampler
   assign bus.mux_out = mux_in[bus.sel];

   mux_rr_sampler #(
      .N      (N),
      .SW     (SW),
      .SETTLE (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Global time limit in case the DUT never responds
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name, output int waited);
      waited = 0;
      while (!bus.out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.out_valid) begin
         n_vec++;
         n_miss++;
         $display("[TB] FAIL %s timeout: out_valid got 0, expected 1", name);
      end
   endtask

   // One complete transaction with out_ready held high; caller is at a negedge with DUT idle
   task automatic apply_stimulus(input string name, input logic [31:0] r,
                                 input logic [31:0] m, input logic [4:0] idx,
                                 input logic b);
      int waited;
      bus.req       = r;
      mux_in        = m;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_output({name, " sel"}, 32'(bus.sel), 32'(idx));
      check_output({name, " gnt"}, bus.gnt, 32'd1 << idx);
      check_output({name, " busy"}, 32'(bus.busy), 32'd1);
      wait_valid(name, waited);
      check_output({name, " latency"}, 32'(waited), 32'd2);
      check_output({name, " out_idx"}, 32'(bus.out_idx), 32'(idx));
      check_output({name, " out_bit"}, 32'(bus.out_bit), 32'(b));
      @(negedge clk);
      check_output({name, " valid_drop"}, 32'(bus.out_valid), 32'd0);
      check_output({name, " idle_busy"}, 32'(bus.busy), 32'd0);
      check_output({name, " idle_gnt"}, bus.gnt, 32'd0);
   endtask

   initial begin
      int waited;

      vecs[0]  = '{32'h0000_0010, 32'h0000_0010, 5'd4,  1'b1};
      vecs[1]  = '{32'h0000_0010, 32'hFFFF_FFEF, 5'd4,  1'b0};
      vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 5'd31, 1'b1};
      vecs[3]  = '{32'h8000_0005, 32'h8000_0004, 5'd0,  1'b0};
      vecs[4]  = '{32'h8000_0005, 32'h8000_0004, 5'd2,  1'b1};
      vecs[5]  = '{32'h8000_0005, 32'h8000_0004, 5'd31, 1'b1};
      vecs[6]  = '{32'h8000_0005, 32'h8000_0004, 5'd0,  1'b0};
      vecs[7]  = '{32'h8000_0005, 32'h8000_0004, 5'd2,  1'b1};
      vecs[8]  = '{32'h0000_0003, 32'h0000_0002, 5'd0,  1'b0};
      vecs[9]  = '{32'h0000_0003, 32'h0000_0002, 5'd1,  1'b1};
      vecs[10] = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 5'd2,  1'b0};
      vecs[11] = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 5'd3,  1'b1};

      // Reset with every source requesting
      rst_n         = 1'b0;
      bus.req       = 32'hFFFF_FFFF;
      bus.out_ready = 1'b0;
      mux_in        = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check_output("rst out_valid", 32'(bus.out_valid), 32'd0);
      check_output("rst busy", 32'(bus.busy), 32'd0);
      check_output("rst gnt", bus.gnt, 32'd0);
      check_output("rst sel", 32'(bus.sel), 32'd0);
      check_output("rst out_bit", 32'(bus.out_bit), 32'd0);
      check_output("rst out_idx", 32'(bus.out_idx), 32'd0);
      rst_n = 1'b1;
      apply_stimulus("rst_first", 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b1);

      // Table: single request, wrap of ptr, round-robin order 0,2,31,0,2
      for (int i = 0; i < 12; i++) begin
         apply_stimulus($sformatf("vec%0d", i), vecs[i].req, vecs[i].mux,
                        vecs[i].idx, vecs[i].exp_bit);
      end

      // Backpressure: result and select frozen while the consumer stalls
      bus.req       = 32'h0000_0040;
      mux_in        = 32'h0000_0040;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check_output("bp sel_grant", 32'(bus.sel), 32'd6);
      wait_valid("bp", waited);
      mux_in  = 32'h0;
      bus.req = 32'h0000_00C0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         check_output($sformatf("bp%0d out_bit", i), 32'(bus.out_bit), 32'd1);
         check_output($sformatf("bp%0d out_idx", i), 32'(bus.out_idx), 32'd6);
         check_output($sformatf("bp%0d sel", i), 32'(bus.sel), 32'd6);
         check_output($sformatf("bp%0d gnt", i), bus.gnt, 32'h0000_0040);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_output("bp hs out_valid", 32'(bus.out_valid), 32'd0);
      check_output("bp hs busy", 32'(bus.busy), 32'd0);
      check_output("bp hs gnt", bus.gnt, 32'd0);
      apply_stimulus("bp_next", 32'h0000_00C0, 32'h0, 5'd7, 1'b0);

      // Request withdrawn during SETTLE: committed grant still completes
      bus.req = 32'h0000_0200;
      mux_in  = 32'h0000_0200;
      @(negedge clk);
      check_output("drop sel", 32'(bus.sel), 32'd9);
      bus.req = 32'h0;
      wait_valid("drop", waited);
      check_output("drop out_idx", 32'(bus.out_idx), 32'd9);
      check_output("drop out_bit", 32'(bus.out_bit), 32'd1);
      @(negedge clk);
      check_output("drop out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check_output("drop busy", 32'(bus.busy), 32'd0);
      check_output("drop gnt", bus.gnt, 32'd0);

      // Move ptr to 2 so the post-reset grant reveals whether ptr was cleared
      apply_stimulus("pre_rst", 32'h0000_0002, 32'h0, 5'd1, 1'b0);

      // Reset while a result is held
      bus.req       = 32'h0000_0008;
      mux_in        = 32'h0000_0008;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check_output("mrst sel", 32'(bus.sel), 32'd3);
      wait_valid("mrst", waited);
      #2 rst_n = 1'b0;
      #1;
      check_output("mrst out_valid", 32'(bus.out_valid), 32'd0);
      check_output("mrst busy", 32'(bus.busy), 32'd0);
      check_output("mrst gnt", bus.gnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus("post_rst", 32'h0000_0006, 32'h0000_0002, 5'd1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
